// File: rtl/msrv32_data_mem_responder.sv
// Data-memory responder for the load/store units.
// Accepts one request at a time over req/ack, waits a fixed number of
// cycles, then commits a byte-masked store or captures load data from
// the internal word-organised array. Out-of-range or misaligned
// addresses are acked with err_out and never touch the array.
module msrv32_data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  wmask_in,
  output logic        ack_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic        busy_out
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  // Byte span of the array; one extra bit so BASE_ADDR + span never wraps.
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          cnt;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic                we_p0;
  logic [31:0]         addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [3:0]          wmask_p0;

  logic                accept;
  logic                commit;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [3:0]          sel_wmask;
  logic                sel_err;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   rd_word;

  // Misaligned, below the window, or at/after its end.
  function automatic logic addr_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, off} >= SPAN);
  endfunction

  // Word index relative to the window base.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  // Byte-lane merge of new store data over the current word.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [3:0]        mask);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Select the request fields used at the commit edge: live inputs when
  // committing straight out of IDLE, latched copies otherwise.
  always_comb begin
    accept    = (state == S_IDLE) && req_in && !rst_in;
    commit    = !rst_in && (((state == S_IDLE) && req_in && NO_WAIT) ||
                            ((state == S_WAIT) && (cnt == 4'd0)));
    sel_we    = we_p0;
    sel_addr  = addr_p0;
    sel_wdata = wdata_p0;
    sel_wmask = wmask_p0;
    if (state == S_IDLE) begin
      sel_we    = we_in;
      sel_addr  = addr_in;
      sel_wdata = wdata_in;
      sel_wmask = wmask_in;
    end
    sel_err = addr_err(sel_addr);
    sel_idx = word_idx(sel_addr);
    rd_word = mem[sel_idx];
  end

  // Stage p0: capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      we_p0    <= we_in;
      addr_p0  <= addr_in;
      wdata_p0 <= wdata_in;
      wmask_p0 <= wmask_in;
    end
  end

  // Array write on the commit edge; errors and resets suppress it.
  always_ff @(posedge clk_in) begin
    if (commit && sel_we && !sel_err) begin
      mem[sel_idx] <= lane_merge(rd_word, sel_wdata, sel_wmask);
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ack_out   <= 1'b0;
      err_out   <= 1'b0;
      busy_out  <= 1'b0;
      rdata_out <= '0;
    end else begin
      ack_out <= 1'b0;
      err_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_in) begin
            busy_out <= 1'b1;
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end
      endcase
      if (commit) begin
        ack_out   <= 1'b1;
        err_out   <= sel_err;
        rdata_out <= sel_err ? '0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_data_mem_responder.sv
// Bench for msrv32_data_mem_responder: three instances with different
// wait-state counts and base addresses, a reference word array, and an
// ack-driven scoreboard.
module tb_msrv32_data_mem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  wmask [NI];
  logic        ack   [NI];
  logic [31:0] rdata [NI];
  logic        err   [NI];
  logic        busy  [NI];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    int          inst;
    logic        err;
    logic        known;
    logic [31:0] rdata;
    int          ack_edge;
  } exp_t;

  exp_t        sb [$];
  exp_t        e_mon;
  logic [31:0] ref_mem [NI][DEPTH];
  bit          ref_vld [NI][DEPTH];

  msrv32_data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .req_in(req[0]), .we_in(we[0]), .addr_in(addr[0]),
    .wdata_in(wdata[0]), .wmask_in(wmask[0]), .ack_out(ack[0]), .rdata_out(rdata[0]),
    .err_out(err[0]), .busy_out(busy[0]));

  msrv32_data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .req_in(req[1]), .we_in(we[1]), .addr_in(addr[1]),
    .wdata_in(wdata[1]), .wmask_in(wmask[1]), .ack_out(ack[1]), .rdata_out(rdata[1]),
    .err_out(err[1]), .busy_out(busy[1]));

  msrv32_data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h100), .WAIT_CYCLES(3)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .req_in(req[2]), .we_in(we[2]), .addr_in(addr[2]),
    .wdata_in(wdata[2]), .wmask_in(wmask[2]), .ack_out(ack[2]), .rdata_out(rdata[2]),
    .err_out(err[2]), .busy_out(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int w_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 2) ? 32'h100 : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: compute the expected response and update the array.
  task automatic model_push(input int i, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m, input int ack_edge);
    exp_t        x;
    logic [31:0] off;
    int          idx;
    off        = a - base_of(i);
    x.inst     = i;
    x.ack_edge = ack_edge;
    x.err      = (a[1:0] != 2'b00) || (a < base_of(i)) || (off >= 32'(4 * DEPTH));
    x.rdata    = 32'h0;
    x.known    = 1'b1;
    if (!x.err) begin
      idx     = int'(off >> 2);
      x.rdata = ref_mem[i][idx];
      x.known = ref_vld[i][idx];
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (m[b]) ref_mem[i][idx][8*b +: 8] = d[8*b +: 8];
        end
        if (m == 4'hF) ref_vld[i][idx] = 1'b1;
      end
    end
    sb.push_back(x);
  endtask

  // One request: hold req until ack, scramble inputs after acceptance.
  task automatic do_txn(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    bit got;
    got = 1'b0;
    model_push(i, w, a, d, m, cyc + 1 + w_of(i));
    we[i] = w; addr[i] = a; wdata[i] = d; wmask[i] = m; req[i] = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      we[i] = ~w; addr[i] = ~a; wdata[i] = ~d; wmask[i] = ~m;
      if (ack[i]) got = 1'b1;
    end
    req[i] = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack[i]), 32'd0);
    check("busy_clear", 32'(busy[i]), 32'd0);
  endtask

  // Scoreboard: every ack pops one expected response.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ack[i] === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("spurious_ack%0d", i), 32'd1, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          check("ack_inst", 32'(i), 32'(e_mon.inst));
          check("err", 32'(err[i]), 32'(e_mon.err));
          if (e_mon.known) check("rdata", rdata[i], e_mon.rdata);
          check("latency", 32'(cyc), 32'(e_mon.ack_edge));
          check("busy_at_ack", 32'(busy[i]), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wmask[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        ref_mem[i][j] = '0;
        ref_vld[i][j] = 1'b0;
      end
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("rst_ack", 32'(ack[i]), 32'd0);
      check("rst_err", 32'(err[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_rdata", rdata[i], 32'h0);
    end

    // Instance 0: one wait state, base 0.
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    do_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
    do_txn(0, 1'b0, 32'h22, 32'h0, 4'hF);
    do_txn(0, 1'b1, 32'h10, 32'h01234567, 4'h0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_txn(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF);
    do_txn(0, 1'b1, 32'h100, 32'h5A5A5A5A, 4'hF);
    do_txn(0, 1'b0, 32'hFC, 32'h0, 4'h0);
    do_txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_txn(0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0);

    // Instance 1: no wait states, request held across two transactions.
    do_txn(1, 1'b1, 32'h8, 32'h12345678, 4'hF);
    do_txn(1, 1'b1, 32'hC, 32'h9ABCDEF0, 4'hF);
    c = cyc;
    model_push(1, 1'b0, 32'h8, 32'h0, 4'h0, c + 1);
    we[1] = 1'b0; addr[1] = 32'h8; req[1] = 1'b1;
    @(posedge clk); #1;
    check("held_ack1", 32'(ack[1]), 32'd1);
    check("held_busy1", 32'(busy[1]), 32'd1);
    addr[1] = 32'hC;
    model_push(1, 1'b0, 32'hC, 32'h0, 4'h0, c + 3);
    @(posedge clk); #1;
    check("held_gap_ack", 32'(ack[1]), 32'd0);
    check("held_gap_busy", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;
    check("held_ack2", 32'(ack[1]), 32'd1);
    check("held_busy2", 32'(busy[1]), 32'd1);
    req[1] = 1'b0;
    @(posedge clk); #1;
    check("held_end_ack", 32'(ack[1]), 32'd0);
    check("held_end_busy", 32'(busy[1]), 32'd0);

    // Instance 2: three wait states, base 0x100.
    do_txn(2, 1'b1, 32'h140, 32'h77777777, 4'hF);
    do_txn(2, 1'b0, 32'h140, 32'h0, 4'h0);
    we[2] = 1'b1; addr[2] = 32'h140; wdata[2] = 32'h55; wmask[2] = 4'hF; req[2] = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ack", 32'(ack[2]), 32'd0);
    check("abort_busy_clr", 32'(busy[2]), 32'd0);
    check("abort_err", 32'(err[2]), 32'd0);
    check("abort_rdata", rdata[2], 32'h0);
    repeat (6) @(posedge clk);
    #1 check("abort_idle", 32'(busy[2]), 32'd0);
    do_txn(2, 1'b0, 32'h140, 32'h0, 4'h0);
    do_txn(2, 1'b0, 32'hFC, 32'h0, 4'h0);
    do_txn(2, 1'b1, 32'h100, 32'hA5A51234, 4'hF);
    do_txn(2, 1'b1, 32'h1FC, 32'h600DCAFE, 4'hF);
    do_txn(2, 1'b0, 32'h100, 32'h0, 4'h0);
    do_txn(2, 1'b0, 32'h1FC, 32'h0, 4'h0);
    do_txn(2, 1'b1, 32'h200, 32'hFFFFFFFF, 4'hF);
    do_txn(2, 1'b0, 32'h1FC, 32'h0, 4'h0);

    // Reset together with a request: the request is dropped.
    rst = 1'b1; req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h100;
    @(posedge clk); #1;
    check("rst_req_busy", 32'(busy[2]), 32'd0);
    rst = 1'b0; req[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("rst_req_idle", 32'(busy[2]), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/msrv32_data_mem_responder.md
Name: msrv32_data_mem_responder

Overview:
- Data-memory responder that services load/store requests whose effective address comes from the immediate adder (rs_1 + imm) in the pipeline.
- Accepts a request over a req/ack handshake, optionally inserts wait states, then commits the write or returns read data with a one-cycle ack.
- Sits between the store/load units and the on-chip data RAM.
- Memory array is internal, word-organised, with per-byte write masks.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2, ≥4).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 (word-aligned).
- WAIT_CYCLES, 1, wait states inserted before the access completes (0..15).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- req_in  input  1  request valid; held high by the requester until ack_out.
- we_in  input  1  1 = store, 0 = load.
- addr_in  input  32  byte address (iadder_out).
- wdata_in  input  32  store data, already lane-aligned.
- wmask_in  input  4  byte write enables; bit i controls wdata_in[8i+7:8i].
- ack_out  output  1  one-cycle completion pulse.
- rdata_out  output  32  load data; valid while ack_out = 1, otherwise held.
- err_out  output  1  valid with ack_out; access rejected.
- busy_out  output  1  high from acceptance until the ack cycle, inclusive.

Behaviour:
- Single clock domain (clk_in). Reset is synchronous and active-high (rst_in).
- Reset values:
  - ack_out = 0, err_out = 0, busy_out = 0, rdata_out = 32'h0.
  - State = IDLE, wait counter = 0.
  - Array contents are not reset.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - If req_in = 1, latch we/addr/wdata/wmask and set busy_out = 1.
  - Go to WAIT with counter = WAIT_CYCLES - 1 when WAIT_CYCLES > 0.
  - Go directly to RESP when WAIT_CYCLES = 0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter = 0, go to RESP on the next edge.
- RESP:
  - ack_out = 1 for exactly one cycle; err_out and rdata_out are valid.
  - Next state is IDLE.
- Latency: request accepted at edge N gives ack_out high in cycle N + WAIT_CYCLES + 1.
- Commit point: the array access (write, or read capture into rdata_out) occurs on the edge that enters RESP, using the latched values.
- Input changes after acceptance are ignored.
- Back-to-back requests:
  - req_in is not sampled in WAIT or RESP.
  - If req_in is still high in the IDLE cycle after ack, it is a new request.
  - Requesters deassert req_in in the ack cycle to avoid a duplicate.
- Error conditions (err_out = 1 with ack):
  - addr[1:0] != 2'b00 (misaligned), or
  - addr < BASE_ADDR, or
  - addr ≥ BASE_ADDR + 4*DEPTH_WORDS.
  - On error: no write occurs, and rdata_out = 32'h0.
- Word index: (addr - BASE_ADDR) >> 2, using log2(DEPTH_WORDS) bits.
  - Range check is done on the full 32-bit subtraction; there is no wrap-around aliasing.
- Store:
  - Only bytes with wmask bit set are updated.
  - wmask = 4'b0000 is a legal no-op store, acked with err_out = 0.
  - On a store ack, rdata_out returns the word value before the write.
- Load: wmask_in is ignored; the full word is returned.
- rdata_out holds its value outside ack cycles.
- Reset mid-operation:
  - rst_in high on any edge forces IDLE and clears the outputs.
  - A pending write whose commit edge coincides with or follows reset is not performed.
  - No ack is issued for the aborted request.
- Reset and req_in together: reset wins and the request is not accepted.

Test Plan:
- Store/load, WAIT_CYCLES = 1:
  - Store 0xDEADBEEF, mask 4'hF, to 0x10 → ack at cycle +2, err_out = 0.
  - Load 0x10 → rdata_out = 0xDEADBEEF, ack at +2.
- Byte mask:
  - Word 0x20 holds 0x11223344; store 0xAABBCCDD with mask 4'b0101.
  - Load 0x20 → 0x11BB33DD.
- Errors:
  - Load 0x22 → ack with err_out = 1, rdata_out = 0.
  - Store to BASE_ADDR + 4*DEPTH_WORDS → err_out = 1, array unchanged (load of last word returns its prior value).
- Back-to-back and held request, WAIT_CYCLES = 0:
  - req_in held high for 4 cycles → ack in cycles 2 and 4.
  - busy_out high in cycles 1–2 and 3–4.
  - Inputs changed during busy are ignored.
- Reset mid-operation, WAIT_CYCLES = 3:
  - Store 0x55 to 0x40; rst_in pulsed in WAIT → no ack, outputs 0.
  - Load 0x40 → prior value.
- Boundary addresses:
  - Store/load BASE_ADDR and BASE_ADDR + 4*(DEPTH_WORDS-1) → correct data, err_out = 0.
  - Address BASE_ADDR - 4 → err_out = 1.
